// File: rtl/seq_bin2bcd_pkg.sv
// Shared calculator definitions: FSM encodings, display glyph codes and default operand sizes.
package seq_bin2bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] MINUS_GLYPH = 4'b1010;
  localparam logic [3:0] BLANK_GLYPH = 4'b1100;

  localparam int DEF_BIN_W  = 9;
  localparam int DEF_DIGITS = 3;

  function automatic logic bcd_digit_invalid(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/seq_bin2bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the next left shift.
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/seq_bin2bcd.sv
// Multi-cycle signed binary -> sign + BCD converter behind a start/done handshake.
// start accepted at edge N gives a done pulse in cycle N+BIN_W+2; start is ignored unless idle.
module seq_bin2bcd
  import seq_bin2bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  ovf
);

  localparam int SW = 4*DIGITS + 1;
  localparam int CW = $clog2(BIN_W + 1);

  state_e              state_q, state_d;
  logic [SW-1:0]       scr_q, scr_d;
  logic [BIN_W-1:0]    mag_q, mag_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                negr_q, negr_d;
  logic                lost_q, lost_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;

  logic [4*DIGITS-1:0] adj_dig;
  logic [SW-1:0]       adj;
  logic                dig_bad;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d_i (scr_q[4*g +: 4]),
      .d_o (adj_dig[4*g +: 4])
    );
  end

  // The top scratch bit is the overflow carry and never gets corrected.
  assign adj = {scr_q[SW-1], adj_dig};

  always_comb begin
    dig_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_bad = dig_bad | bcd_digit_invalid(scr_q[4*i +: 4]);
    end
  end

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    negr_d  = negr_q;
    lost_d  = lost_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_d   = bin_in;
          busy_d  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Negating the most negative value wraps to itself, which read unsigned is the right magnitude.
        negr_d  = mag_q[BIN_W-1];
        mag_d   = mag_q[BIN_W-1] ? -mag_q : mag_q;
        scr_d   = '0;
        lost_d  = 1'b0;
        cnt_d   = CW'(BIN_W);
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        scr_d  = {adj[SW-2:0], mag_q[BIN_W-1]};
        mag_d  = {mag_q[BIN_W-2:0], 1'b0};
        lost_d = lost_q | adj[SW-1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = scr_q[SW-2:0];
        neg_d   = negr_q;
        ovf_d   = lost_q | scr_q[SW-1] | dig_bad;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      scr_q   <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      negr_q  <= 1'b0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      negr_q  <= negr_d;
      lost_q  <= lost_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: 9-bit/3-digit instance for the main behaviour, 12-bit instance for overflow.
module tb_seq_bin2bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        start;
  logic [8:0]  bin_in;
  logic        busy, done, neg, ovf;
  logic [11:0] bcd_out;

  logic        start_w;
  logic [11:0] bin_w;
  logic        busy_w, done_w, neg_w, ovf_w;
  logic [11:0] bcd_w;

  seq_bin2bcd #(.BIN_W(9), .DIGITS(3)) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .neg(neg), .ovf(ovf)
  );

  seq_bin2bcd #(.BIN_W(12), .DIGITS(3)) dut_w (
    .CLOCK_50(clk), .resetn(resetn), .start(start_w), .bin_in(bin_w),
    .busy(busy_w), .done(done_w), .bcd_out(bcd_w), .neg(neg_w), .ovf(ovf_w)
  );

  typedef struct packed {
    logic [11:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t sb_w[$];
  exp_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic exp_t model(input int unsigned raw, input int w);
    int unsigned mag, d;
    exp_t e;
    e.neg = raw[w-1];
    mag   = raw[w-1] ? ((32'd1 << w) - raw) : raw;
    e.ovf = (mag > 999);
    d     = mag % 1000;
    e.bcd = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
    return e;
  endfunction

  task automatic start_conv(input logic [8:0] v);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    sb.push_back(model(32'(v), 9));
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = ~v;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else cyc++;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0; bin_in = '0; start_w = 1'b0; bin_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, bcd_out, neg, ovf} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset9: got %h want 0000", {busy, done, bcd_out, neg, ovf});
    end
    vectors++;
    if ({busy_w, done_w, bcd_w, neg_w, ovf_w} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset12: got %h want 0000", {busy_w, done_w, bcd_w, neg_w, ovf_w});
    end
    resetn = 1'b1;
    last_exp = '0;
  endtask

  task automatic test_zero;
    int cyc; bit seen; exp_t e;
    start_conv(9'd0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_busy: got %b want 1", busy);
    end
    wait_done(cyc, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || cyc != 11) begin
      miscompares++;
      $display("FAIL zero_latency: got seen=%0b cyc=%0d want cyc=11", seen, cyc);
    end
    vectors++;
    if ({bcd_out, neg, ovf, busy} !== {e, 1'b0}) begin
      miscompares++;
      $display("FAIL zero_result: got %h/%b/%b busy=%b want %h/%b/%b busy=0",
               bcd_out, neg, ovf, busy, e.bcd, e.neg, e.ovf);
    end
    last_exp = e;
  endtask

  task automatic test_convert;
    logic [8:0] vals[$];
    int cyc; bit seen; exp_t e;
    vals = '{9'd255, 9'h1FF, 9'h100, 9'd1, 9'd100, 9'h19C};
    for (int i = 0; i < 6; i++) vals.push_back(9'($urandom_range(0, 511)));
    foreach (vals[k]) begin
      start_conv(vals[k]);
      wait_done(cyc, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen || {bcd_out, neg, ovf} !== e) begin
        miscompares++;
        $display("FAIL convert_%h: got seen=%0b %h/%b/%b want %h/%b/%b",
                 vals[k], seen, bcd_out, neg, ovf, e.bcd, e.neg, e.ovf);
      end
      last_exp = e;
    end
  endtask

  task automatic test_ignore_start;
    int cyc, bad_hold, bad_busy, extra_done, late_busy; bit seen; exp_t e;
    bad_hold = 0; bad_busy = 0; extra_done = 0; late_busy = 0;
    start_conv(9'd123);
    cyc = 0; seen = 1'b0;
    bin_in = 9'd45;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = (cyc == 3 || cyc == 10);
      if (done) seen = 1'b1;
      else begin
        if (bcd_out !== last_exp.bcd || neg !== last_exp.neg) bad_hold++;
        if (busy !== 1'b1) bad_busy++;
        cyc++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (!seen || cyc != 11 || {bcd_out, neg, ovf} !== e) begin
      miscompares++;
      $display("FAIL ignore_result: got seen=%0b cyc=%0d %h/%b/%b want cyc=11 %h/%b/%b",
               seen, cyc, bcd_out, neg, ovf, e.bcd, e.neg, e.ovf);
    end
    vectors++;
    if (bad_hold != 0 || bad_busy != 0) begin
      miscompares++;
      $display("FAIL ignore_hold: got %0d unstable %0d not-busy cycles want 0 0", bad_hold, bad_busy);
    end
    repeat (16) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) late_busy++;
    end
    vectors++;
    if (extra_done != 0 || late_busy != 0) begin
      miscompares++;
      $display("FAIL ignore_extra: got %0d extra done %0d busy cycles want 0 0", extra_done, late_busy);
    end
    last_exp = e;
  endtask

  task automatic test_reset_mid;
    int cyc, stray; bit seen; exp_t e;
    stray = 0;
    start_conv(9'd77);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bcd_out, neg, ovf} !== 16'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got %h want 0000", {busy, done, bcd_out, neg, ovf});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (16) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL midreset_stray: got %0d done/busy cycles want 0", stray);
    end
    start_conv(9'h138);
    wait_done(cyc, seen);
    e = sb.pop_front();
    vectors++;
    if (!seen || cyc != 11 || {bcd_out, neg, ovf} !== e) begin
      miscompares++;
      $display("FAIL midreset_next: got seen=%0b cyc=%0d %h/%b/%b want cyc=11 %h/%b/%b",
               seen, cyc, bcd_out, neg, ovf, e.bcd, e.neg, e.ovf);
    end
    last_exp = e;
  endtask

  task automatic test_back_to_back;
    logic [8:0] vals[4];
    int cyc; bit seen; exp_t e;
    vals = '{9'd42, 9'h1F4, 9'd199, 9'h180};
    @(negedge clk);
    bin_in = vals[0];
    start  = 1'b1;
    sb.push_back(model(32'(vals[0]), 9));
    for (int k = 0; k < 4; k++) begin
      wait_done(cyc, seen);
      e = sb.pop_front();
      vectors++;
      if (!seen || cyc != 11 || {bcd_out, neg, ovf} !== e) begin
        miscompares++;
        $display("FAIL b2b_%0d: got seen=%0b cyc=%0d %h/%b/%b want cyc=11 %h/%b/%b",
                 k, seen, cyc, bcd_out, neg, ovf, e.bcd, e.neg, e.ovf);
      end
      last_exp = e;
      if (k < 3) begin
        bin_in = vals[k+1];
        sb.push_back(model(32'(vals[k+1]), 9));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_wide;
    logic [11:0] vals[4];
    int cyc; bit seen; exp_t e;
    vals = '{12'd1000, 12'd999, 12'h800, 12'hC18};
    foreach (vals[k]) begin
      @(negedge clk);
      bin_w   = vals[k];
      start_w = 1'b1;
      sb_w.push_back(model(32'(vals[k]), 12));
      @(posedge clk);
      #1;
      start_w = 1'b0;
      cyc = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (done_w) seen = 1'b1;
        else cyc++;
      end
      e = sb_w.pop_front();
      vectors++;
      if (!seen || cyc != 14 || {bcd_w, neg_w, ovf_w} !== e) begin
        miscompares++;
        $display("FAIL wide_%h: got seen=%0b cyc=%0d %h/%b/%b want cyc=14 %h/%b/%b",
                 vals[k], seen, cyc, bcd_w, neg_w, ovf_w, e.bcd, e.neg, e.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_convert();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
